seg7_scan: RTL and testbench

Parametrised multiplexed seven-segment display driver for N common-select digits. It takes hex nibbles, decimal points and a 4-bit brightness, and scans the digits from an internal prescaler, so no divided scan clock is needed. The block double-buffers the display data so that frames never tear, and supports leading-zero blanking. It sits between the application counters/FSMs and the board's segment/select pins.

---
 rtl/seg7_scan.sv | 193 +++++++++++++++++++
 tb/tb_seg7_scan.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed seven-segment scan driver with double-buffered display data
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   value, dp, load   shadow-buffer write (nibble i / dp bit i belong to digit i)
//   blank_lz          leading-zero blanking enable
//   bright            on-time in 1/16ths of a slot
//   blink_mask        digits to blink (only with SEG7_BLINK_EN defined)
//   seg, dp_out, sel  registered segment / decimal point / one-hot digit select pins
//   frame_done        one-cycle pulse on the last cycle of each frame
// Optional feature macro: SEG7_BLINK_EN (32-frame blink of digits in blink_mask).
module seg7_scan #(
  parameter int DIGITS         = 4,
  parameter int CLK_HZ         = 12_000_000,
  parameter int SCAN_HZ        = 2000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);
  localparam int SUB = CLK_HZ / (SCAN_HZ * 16);
  localparam int PW  = (SUB > 1) ? $clog2(SUB) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SUB - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  if (SUB < 1) begin : g_sub_check
    $error("seg7_scan: CLK_HZ/(SCAN_HZ*16) must be at least 1");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_digits_check
    $error("seg7_scan: DIGITS must be in 1..8");
  end

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  logic [PW-1:0]       pre_q, pre_d;
  logic [3:0]          phase_q, phase_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_val_q, act_val_q;
  logic [DIGITS-1:0]   shadow_dp_q, act_dp_q;
  logic                pending_q;
  logic [6:0]          seg_q, seg_d;
  logic                dp_out_q, dp_out_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                frame_done_q;
  logic                tick, slot_last, frame_last, copy;
  logic [DIGITS-1:0]   blink_dark_mask;

  assign tick       = (pre_q == PRE_LAST);
  assign slot_last  = tick && (phase_q == 4'd15);
  assign frame_last = slot_last && (idx_q == IDX_LAST);
  // Swap buffers only at the very first cycle of slot 0 so a frame never tears.
  assign copy       = pending_q && (pre_q == '0) && (phase_q == 4'd0) && (idx_q == '0);

  always_comb begin
    pre_d   = tick ? '0 : pre_q + PW'(1);
    phase_d = tick ? phase_q + 4'd1 : phase_q;
    idx_d   = idx_q;
    if (slot_last) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q        <= '0;
      phase_q      <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      pending_q    <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      if (copy) begin
        act_val_q <= shadow_val_q;
        act_dp_q  <= shadow_dp_q;
      end
      if (load) begin
        shadow_val_q <= value;
        shadow_dp_q  <= dp;
      end
      // A load coinciding with the copy keeps pending so the new data goes out next frame.
      pending_q <= load || (pending_q && !copy);
    end
  end

`ifdef SEG7_BLINK_EN
  logic [4:0] frame_cnt_q;
  logic       blink_off_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (frame_last) begin
      frame_cnt_q <= frame_cnt_q + 5'd1;
      if (frame_cnt_q == 5'd31) begin
        blink_off_q <= ~blink_off_q;
      end
    end
  end

  assign blink_dark_mask = blink_off_q ? blink_mask : '0;
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blink_dark_mask   = '0;
`endif

  logic [DIGITS-1:0] lz, dsel;
  logic [3:0]        nib;
  logic              lz_run, blanked, dp_bit, lit;

  always_comb begin
    lz      = '0;
    lz_run  = blank_lz;
    // Walk down from the most significant digit; digit 0 is never blanked.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run = lz_run && (act_val_q[4*i +: 4] == 4'h0);
      lz[i]  = lz_run;
    end
    nib     = 4'h0;
    blanked = 1'b0;
    dp_bit  = 1'b0;
    dsel    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib     = act_val_q[4*i +: 4];
        blanked = lz[i];
        dp_bit  = act_dp_q[i];
        dsel[i] = 1'b1;
      end
    end
    // Phase 0 is always dark to stop ghosting while sel moves to the next digit.
    lit      = (phase_q != 4'd0) && (phase_q <= bright) && ((blink_dark_mask & dsel) == '0);
    sel_d    = lit ? dsel : '0;
    seg_d    = (lit && !blanked) ? hex_glyph(nib) : 7'h00;
    dp_out_d = lit && dp_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q        <= {7{SEG_ACTIVE_LOW}};
      dp_out_q     <= SEG_ACTIVE_LOW;
      sel_q        <= {DIGITS{SEL_ACTIVE_LOW}};
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d ^ {7{SEG_ACTIVE_LOW}};
      dp_out_q     <= dp_out_d ^ SEG_ACTIVE_LOW;
      sel_q        <= sel_d ^ {DIGITS{SEL_ACTIVE_LOW}};
      frame_done_q <= frame_last;
    end
  end

  assign seg        = seg_q;
  assign dp_out     = dp_out_q;
  assign sel        = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - table-driven frame checks for seg7_scan (SUB=1, 16-cycle slot, 64-cycle frame)
module tb_seg7_scan;
  localparam int DIGITS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       value;
  logic [3:0]        dp;
  logic              load;
  logic              blank_lz;
  logic [3:0]        bright;
  logic [3:0]        blink_mask;
  logic [6:0]        seg;
  logic              dp_out;
  logic [3:0]        sel;
  logic              frame_done;

  always #5 clk = ~clk;

  seg7_scan #(
    .DIGITS(DIGITS), .CLK_HZ(1600), .SCAN_HZ(100),
    .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
    .blank_lz(blank_lz), .bright(bright), .blink_mask(blink_mask),
    .seg(seg), .dp_out(dp_out), .sel(sel), .frame_done(frame_done)
  );

  // One record = one checked frame; expected glyphs are {digit3, digit2, digit1, digit0}.
  // Optional loads are issued at the given offset inside that frame (-1 = none).
  typedef struct {
    logic [3:0]       bright;
    logic             lz;
    logic [3:0][6:0]  seg;
    logic [3:0]       dpx;
    int               ld_at;
    logic [15:0]      ld_val;
    logic [3:0]       ld_dp;
    int               ld2_at;
    logic [15:0]      ld2_val;
    logic [3:0]       ld2_dp;
  } rec_t;

  rec_t recs[9];
  rec_t rst_rec;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic run_frame(input rec_t r, input int k);
    int         p, d;
    logic       on;
    logic [3:0] esel;
    logic [6:0] es;
    logic       edp;
    bright   = r.bright;
    blank_lz = r.lz;
    for (int off = 0; off < 64; off++) begin
      load = 1'b0;
      if (off == r.ld_at) begin
        load = 1'b1; value = r.ld_val; dp = r.ld_dp;
      end
      if (off == r.ld2_at) begin
        load = 1'b1; value = r.ld2_val; dp = r.ld2_dp;
      end
      @(negedge clk);
      p    = off % 16;
      d    = off / 16;
      on   = (p != 0) && (p <= int'(r.bright));
      esel = on ? 4'(1 << d) : 4'b0000;
      es   = on ? r.seg[d] : 7'h00;
      edp  = on ? r.dpx[d] : 1'b0;
      check($sformatf("frame%0d_off%0d", k, off),
            {3'b000, sel, seg, dp_out, frame_done},
            {3'b000, esel, es, edp, (off == 63)});
    end
    load = 1'b0;
  endtask

  initial begin
    recs[0] = '{4'd15, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000,  0, 16'h1234, 4'b0100, -1, 16'h0000, 4'h0};
    recs[1] = '{4'd15, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, 37, 16'h00A0, 4'b0000, -1, 16'h0000, 4'h0};
    recs[2] = '{4'd15, 1'b0, {7'h3F, 7'h3F, 7'h77, 7'h3F}, 4'b0000, 10, 16'h00A0, 4'b0000, -1, 16'h0000, 4'h0};
    recs[3] = '{4'd15, 1'b1, {7'h00, 7'h00, 7'h77, 7'h3F}, 4'b0000, 63, 16'h0005, 4'b0001, -1, 16'h0000, 4'h0};
    recs[4] = '{4'd15, 1'b1, {7'h00, 7'h00, 7'h00, 7'h6D}, 4'b0001,  0, 16'h0000, 4'b0000, -1, 16'h0000, 4'h0};
    recs[5] = '{4'd15, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, 30, 16'h8001, 4'b1000, -1, 16'h0000, 4'h0};
    recs[6] = '{4'd4,  1'b1, {7'h7F, 7'h3F, 7'h3F, 7'h06}, 4'b1000, -1, 16'h0000, 4'b0000, -1, 16'h0000, 4'h0};
    recs[7] = '{4'd0,  1'b0, {7'h7F, 7'h3F, 7'h3F, 7'h06}, 4'b1000,  5, 16'hFFFF, 4'b1111, 40, 16'hC0DE, 4'b0001};
    recs[8] = '{4'd1,  1'b1, {7'h39, 7'h3F, 7'h5E, 7'h79}, 4'b0001, -1, 16'h0000, 4'b0000, -1, 16'h0000, 4'h0};
    rst_rec = '{4'd15, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, -1, 16'h0000, 4'b0000, -1, 16'h0000, 4'h0};

    rst = 1'b1; value = '0; dp = '0; load = 1'b0;
    blank_lz = 1'b0; bright = 4'd15; blink_mask = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {3'b000, sel, seg, dp_out, frame_done}, 16'h0000);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) run_frame(recs[k], k);

    // Mid-frame reset while slot 2 is lit.
    bright = 4'd15; blank_lz = 1'b0;
    for (int i = 0; i < 40; i++) @(negedge clk);
    check("pre_reset_slot2", {5'b00000, sel, seg}, {5'b00000, 4'b0100, 7'h3F});
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {3'b000, sel, seg, dp_out, frame_done}, 16'h0000);
    @(negedge clk);
`ifdef SEG7_BLINK_EN
    blink_mask = 4'b0001;
`endif
    rst = 1'b0;
    run_frame(rst_rec, 100);

`ifdef SEG7_BLINK_EN
    for (int f = 1; f < 66; f++) begin
      for (int off = 0; off < 64; off++) begin
        @(negedge clk);
        if (off == 1)
          check($sformatf("blink_d0_f%0d", f), {12'h000, sel},
                {12'h000, ((f % 64) >= 32) ? 4'b0000 : 4'b0001});
        if (off == 17)
          check($sformatf("blink_d1_f%0d", f), {12'h000, sel}, 16'h0002);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
